// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - four-requester round-robin arbiter into a single registered output word
// Requester i's data is taken (ack[i]) only when the output register is free or being drained this cycle.
module mux_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic             out_ready,
  output logic [3:0]       ack,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [1:0]       sel
);

  logic [1:0]       ptr;
  logic [1:0]       win;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] win_data;

  assign load = (req != 4'b0000) && (!out_valid || out_ready);

  // Scan from the pointer upward; 2-bit addition gives the mod-4 wrap for free.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!found && req[ptr + 2'(k)]) begin
        win   = ptr + 2'(k);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_data = in1;
    case (win)
      2'd0: win_data = in1;
      2'd1: win_data = in2;
      2'd2: win_data = in3;
      2'd3: win_data = in4;
      default: win_data = in1;
    endcase
  end

  // Reset gates ack too, so nothing is acknowledged while the output is being flushed.
  always_comb begin
    ack = 4'b0000;
    if (load && !rst) begin
      ack[win] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      sel       <= 2'd0;
      ptr       <= 2'd0;
    end else if (load) begin
      out       <= win_data;
      sel       <= win;
      out_valid <= 1'b1;
      ptr       <= win + 2'd1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of every in/out data port.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, an asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 4 bits, where req[i] means requester i holds valid data.
REQ-005 The block SHALL have ports in1, in2, in3, in4, input, WIDTH bits each, carrying the data of requesters 0, 1, 2 and 3.
REQ-006 The block SHALL have port ack, output, 4 bits, one-hot or zero, where ack[i] means requester i's data is taken this cycle.
REQ-007 The block SHALL have port out, output, WIDTH bits, the registered data of the granted requester.
REQ-008 The block SHALL have port out_valid, output, 1 bit, meaning out holds an untaken word.
REQ-009 The block SHALL have port out_ready, input, 1 bit, meaning the downstream consumer takes out this cycle when out_valid=1.
REQ-010 The block SHALL have port sel, output, 2 bits, the registered index (0-3) of the requester whose data is in out.

Function
REQ-011 The block SHALL define combinational load = (req != 0) && (!out_valid || out_ready).
REQ-012 The block SHALL keep a 2-bit round-robin pointer ptr and pick winner w as the first index in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[w]=1.
REQ-013 The block SHALL drive ack combinationally as ack[w]=1 when load=1, and ack=0 in every other case.
REQ-014 On a clock edge with load=1, the block SHALL load out with the data of w (in1 for w=0, through in4 for w=3), set sel to w, set out_valid to 1, and set ptr to (w+1) mod 4.
REQ-015 On a clock edge with load=0, out_valid=1 and out_ready=1, the block SHALL clear out_valid to 0 and hold out, sel and ptr.
REQ-016 On a clock edge with load=0 and no transfer, the block SHALL hold out, sel, out_valid and ptr unchanged.
REQ-017 The block SHALL support back-to-back transfers: with out_ready=1 and requests present, it SHALL produce one word per cycle.
REQ-018 While out_valid=1 and out_ready=0, the block SHALL hold out and sel stable and keep ack=0.
REQ-019 A requester SHALL hold req and its data stable until it sees ack; the block SHALL sample the data only in its ack cycle.
REQ-020 A requester MAY drop req in the cycle after ack; if req stays high, the request SHALL be treated as a new word.
REQ-021 Under continuous requests, each requester SHALL be granted at least once in every 4 consecutive grants (no starvation).
REQ-022 The pointer SHALL wrap: a grant to index 3 SHALL set ptr to 0.
REQ-023 When req=0, the block SHALL issue no ack and hold ptr.
REQ-024 A req change in the same cycle as an out_ready transfer SHALL follow REQ-011 to REQ-016 with no special case.

Reset
REQ-025 While rst=1, the block SHALL force out=0, out_valid=0, sel=0 and ptr=0, independent of clk.
REQ-026 While rst=1, the block SHALL force ack=0.
REQ-027 A reset asserted while out_valid=1 SHALL discard the pending word.
REQ-028 After rst deasserts, the first arbitration SHALL start from ptr=0.

Verification
REQ-029 Scenario: release reset with req=4'b0000 -> out=0, out_valid=0, sel=0, ack=0 held for 5 cycles.
REQ-030 Scenario: req=4'b1111, in1..in4=0x11/0x22/0x33/0x44, out_ready=1 for 5 cycles -> out=0x11, 0x22, 0x33, 0x44, 0x11 on successive cycles; sel=0, 1, 2, 3, 0; ack one-hot rotating 0001, 0010, 0100, 1000, 0001.
REQ-031 Scenario: req=4'b0100 with in3=0xA5 and out_ready=0 for 3 cycles -> ack=0100 in the first cycle only; out=0xA5, sel=2, out_valid=1 held; raising out_ready for one cycle with req=0 -> out_valid=0 on the next cycle.
REQ-032 Scenario: grant index 2, then set req=4'b0101 -> the next grant goes to index 0 by wrap-around after 3 is skipped (ack=0001), and the following grant goes to index 2.
REQ-033 Scenario: assert rst asynchronously while out_valid=1 and out=0x44 -> out=0 and out_valid=0 take effect without waiting for a clk edge; after release with req=4'b1000, the first grant is index 3 and ptr=0.
REQ-034 Scenario: random req and out_ready over 10k cycles -> the bench checks ack is one-hot or zero, no word is lost or duplicated relative to a reference model, and every index is granted within 4 grants of its request.
